// File: rtl/cmd_responder_if.sv
// rtl/cmd_responder_if.sv - command-responder handshake bundle: request, register read port, tx stream
interface cmd_responder_if;
    logic        rd_start;
    logic [5:0]  rd_cmd;
    logic [15:0] rd_len;
    logic        busy;
    logic        reg_read;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  rd_start, rd_cmd, rd_len, reg_data_out, tx_ready,
        output busy, reg_read, reg_bytecount, tx_data, tx_valid
    );

    modport slave (
        output rd_start, rd_cmd, rd_len, reg_data_out, tx_ready,
        input  busy, reg_read, reg_bytecount, tx_data, tx_valid
    );
endinterface

// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - frames read responses (header, length, data) with a prefetching register fetch engine
module cmd_responder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_usb,
    input  logic             rst_n,
    cmd_responder_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA
    } state_t;

    state_t      state;
    logic        busy_q;
    logic [7:0]  hdr_q;
    logic [15:0] len_q;
    logic [15:0] send_cnt;
    logic [15:0] fetch_cnt;
    logic        fetch_pend;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;

    logic          accept;
    logic          hs;
    logic          pop;
    logic          push;
    logic          fetch;
    logic [AW+1:0] credit;
    logic          tx_valid_c;
    logic [7:0]    tx_data_c;

    assign accept = !busy_q && bus.rd_start;

    // tx outputs are a pure mux of state, latched header/length and FIFO storage
    always_comb begin
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        case (state)
            S_HDR:    begin tx_valid_c = 1'b1; tx_data_c = hdr_q;       end
            S_LEN_LO: begin tx_valid_c = 1'b1; tx_data_c = len_q[7:0];  end
            S_LEN_HI: begin tx_valid_c = 1'b1; tx_data_c = len_q[15:8]; end
            S_DATA:   begin tx_valid_c = (fifo_cnt != '0); tx_data_c = fifo_mem[rd_ptr]; end
            default:  begin tx_valid_c = 1'b0; tx_data_c = 8'h00;       end
        endcase
    end

    assign hs   = tx_valid_c && bus.tx_ready;
    assign pop  = hs && (state == S_DATA);
    assign push = fetch_pend;

    // A pop in this cycle frees a slot, which keeps the stream gap-free even at depth 2
    assign credit = (AW+2)'(fifo_cnt) + (AW+2)'(fetch_pend) - (AW+2)'(pop);
    assign fetch  = busy_q && (fetch_cnt != len_q) && (credit < (AW+2)'(FIFO_DEPTH));

    assign bus.tx_valid      = tx_valid_c;
    assign bus.tx_data       = tx_data_c;
    assign bus.busy          = busy_q;
    assign bus.reg_read      = fetch;
    assign bus.reg_bytecount = fetch_cnt;

    always_ff @(posedge clk_usb or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            hdr_q    <= 8'h00;
            len_q    <= 16'h0000;
            send_cnt <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.rd_start) begin
                        state    <= S_HDR;
                        busy_q   <= 1'b1;
                        hdr_q    <= {2'b10, bus.rd_cmd};
                        len_q    <= bus.rd_len;
                        send_cnt <= 16'h0000;
                    end
                end
                S_HDR:    if (hs) state <= S_LEN_LO;
                S_LEN_LO: if (hs) state <= S_LEN_HI;
                S_LEN_HI: begin
                    if (hs) begin
                        if (len_q != 16'h0000) begin
                            state <= S_DATA;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        if (send_cnt == len_q - 16'd1) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            send_cnt <= send_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_usb or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= 16'h0000;
            fetch_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else if (accept) begin
            fetch_cnt  <= 16'h0000;
            fetch_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            fetch_pend <= fetch;
            if (fetch) fetch_cnt <= fetch_cnt + 16'd1;
            if (push)  wr_ptr    <= wr_ptr + AW'(1);
            if (pop)   rd_ptr    <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_usb) begin
        if (push) fifo_mem[wr_ptr] <= bus.reg_data_out;
    end
endmodule

// File: tb/tb_cmd_responder.sv
// tb/tb_cmd_responder.sv - randomized and directed bench for cmd_responder with a frame-level reference model
module tb_cmd_responder;
    localparam int DEPTH = 4;

    logic clk_usb = 1'b0;
    logic rst_n;

    cmd_responder_if bus();

    cmd_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_usb (clk_usb),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_usb = ~clk_usb;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // register file contents: byte k = base + k*mul
    logic [7:0] pat_base = 8'h00;
    logic [7:0] pat_mul  = 8'h01;

    function automatic logic [7:0] reg_byte(input logic [15:0] k);
        logic [7:0] kb;
        kb = k[7:0];
        return 8'(pat_base + kb * pat_mul);
    endfunction

    // data is only valid the cycle after a strobe; garbage otherwise
    always @(posedge clk_usb) begin
        if (bus.reg_read) bus.reg_data_out <= reg_byte(bus.reg_bytecount);
        else              bus.reg_data_out <= 8'($urandom);
    end

    // frame-level reference model state
    bit         m_busy = 1'b0;
    logic [7:0] exp_q[$];
    int         m_len = 0, sent = 0, fetched = 0, data_pops = 0, frame_cyc = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] got_q[$];
    int         hs_cyc[$];
    int         idx_q[$];
    int         cyc = 0, total_busy = 0, total_rd = 0;

    always @(negedge clk_usb) begin : mon
        bit was_busy;
        if (!rst_n) begin
            m_busy = 1'b0; exp_q.delete(); m_len = 0; sent = 0; fetched = 0;
            data_pops = 0; frame_cyc = 0; prev_stall = 1'b0;
        end else begin
            was_busy = m_busy;
            cyc++;
            if (bus.busy) total_busy++;
            if (was_busy) frame_cyc++;
            chk("busy", bus.busy, was_busy);
            if (!was_busy) chk("idle_no_valid", bus.tx_valid, 1'b0);
            else if (sent < 3) chk("hdr_valid", bus.tx_valid, 1'b1);
            if (prev_stall) begin
                chk("stall_valid", bus.tx_valid, 1'b1);
                chk("stall_data", bus.tx_data, prev_data);
            end
            if (bus.tx_valid && exp_q.size() > 0) chk("tx_data", bus.tx_data, exp_q[0]);
            if (bus.tx_valid && bus.tx_ready && exp_q.size() > 0) begin
                got_q.push_back(bus.tx_data);
                hs_cyc.push_back(cyc);
                if (sent >= 3) data_pops++;
                sent++;
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    chk("fetch_total", fetched, m_len);
                    m_busy = 1'b0;
                end
            end
            if (bus.reg_read) begin
                chk("fetch_idx", bus.reg_bytecount, fetched);
                chk("fetch_in_range", fetched < m_len, 1'b1);
                fetched++;
                total_rd++;
                idx_q.push_back(int'(bus.reg_bytecount));
                chk("outstanding", (fetched - data_pops) <= DEPTH, 1'b1);
            end
            if (was_busy && frame_cyc == 1 && m_len != 0) chk("first_fetch", bus.reg_read, 1'b1);
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            if (!was_busy && bus.rd_start) begin
                m_len = int'(bus.rd_len);
                m_busy = 1'b1; sent = 0; fetched = 0; data_pops = 0; frame_cyc = 0;
                exp_q.push_back({2'b10, bus.rd_cmd});
                exp_q.push_back(bus.rd_len[7:0]);
                exp_q.push_back(bus.rd_len[15:8]);
                for (int k = 0; k < m_len; k++) exp_q.push_back(reg_byte(16'(k)));
            end
        end
    end

    task automatic step();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic start_frame(input logic [5:0] c, input logic [15:0] l,
                               input logic [7:0] b, input logic [7:0] m, input bit rdy);
        pat_base = b; pat_mul = m;
        bus.rd_cmd = c; bus.rd_len = l; bus.rd_start = 1'b1; bus.tx_ready = rdy;
        step();
        bus.rd_start = 1'b0;
        bus.rd_cmd = 6'($urandom);
        bus.rd_len = 16'($urandom);
    endtask

    // mode 0: ready held high, 1: 30% duty, 2: 50% duty
    task automatic wait_idle(input int mode, input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ($urandom_range(0, 99) < 30);
                default: bus.tx_ready = 1'(($urandom_range(0, 1)));
            endcase
            step();
            n++;
        end
        if (n >= budget) chk("frame_timeout", 32'(n), 32'(budget - 1));
        bus.tx_ready = 1'b1;
    endtask

    logic [7:0] t1[6] = '{8'h85, 8'h03, 8'h00, 8'hA0, 8'hA1, 8'hA2};
    logic [7:0] t6[4] = '{8'h82, 8'h01, 8'h00, 8'hD0};

    initial begin
        int g0, i0, b0, r0;
        rst_n = 1'b0;
        bus.rd_start = 1'b0; bus.rd_cmd = 6'h00; bus.rd_len = 16'h0000; bus.tx_ready = 1'b0;
        step(); step();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_reg_read", bus.reg_read, 1'b0);
        chk("rst_bytecount", bus.reg_bytecount, 16'h0000);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        rst_n = 1'b1;
        step();

        g0 = got_q.size(); i0 = idx_q.size(); b0 = total_busy;
        start_frame(6'h05, 16'd3, 8'hA0, 8'h01, 1'b1);
        wait_idle(0, 100);
        chk("t1_count", got_q.size() - g0, 6);
        for (int i = 0; i < 6; i++) chk("t1_byte", got_q[g0 + i], t1[i]);
        chk("t1_back_to_back", hs_cyc[g0 + 5] - hs_cyc[g0], 5);
        for (int i = 0; i < 3; i++) chk("t1_bytecount", idx_q[i0 + i], i);
        chk("t1_busy_cycles", total_busy - b0, 6);
        chk("t1_busy_low", bus.busy, 1'b0);

        g0 = got_q.size(); b0 = total_busy; r0 = total_rd;
        start_frame(6'h3F, 16'd0, 8'h00, 8'h01, 1'b1);
        wait_idle(0, 100);
        chk("t2_count", got_q.size() - g0, 3);
        chk("t2_hdr", got_q[g0], 8'hBF);
        chk("t2_len_lo", got_q[g0 + 1], 8'h00);
        chk("t2_len_hi", got_q[g0 + 2], 8'h00);
        chk("t2_no_reads", total_rd - r0, 0);
        chk("t2_busy_cycles", total_busy - b0, 3);

        g0 = got_q.size();
        start_frame(6'h0A, 16'd10, 8'h10, 8'h03, 1'b0);
        wait_idle(1, 2000);
        chk("t3_count", got_q.size() - g0, 13);
        chk("t3_hdr", got_q[g0], 8'h8A);
        chk("t3_len_lo", got_q[g0 + 1], 8'h0A);
        chk("t3_len_hi", got_q[g0 + 2], 8'h00);
        chk("t3_d0", got_q[g0 + 3], 8'h10);
        chk("t3_d9", got_q[g0 + 12], 8'h2B);

        g0 = got_q.size(); r0 = total_rd;
        start_frame(6'h11, 16'd16, 8'h40, 8'h01, 1'b0);
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
        repeat (20) step();
        chk("t4_reads_stalled", total_rd - r0, 4);
        chk("t4_sent_stalled", got_q.size() - g0, 1);
        wait_idle(0, 200);
        chk("t4_count", got_q.size() - g0, 19);

        g0 = got_q.size(); b0 = total_busy;
        start_frame(6'h07, 16'd6, 8'h30, 8'h05, 1'b1);
        step(); step();
        bus.rd_start = 1'b1; bus.rd_cmd = 6'h01; bus.rd_len = 16'd2;
        step();
        bus.rd_start = 1'b0;
        wait_idle(0, 100);
        chk("t5_count", got_q.size() - g0, 9);
        chk("t5_hdr", got_q[g0], 8'h87);
        chk("t5_len_lo", got_q[g0 + 1], 8'h06);
        chk("t5_busy_cycles", total_busy - b0, 9);

        start_frame(6'h09, 16'd1, 8'h77, 8'h01, 1'b1);
        step(); step(); step();
        bus.rd_start = 1'b1; bus.rd_cmd = 6'h15; bus.rd_len = 16'd2;
        step();
        bus.rd_start = 1'b0;
        step();
        chk("t5b_final_start_ignored", bus.busy, 1'b0);

        start_frame(6'h04, 16'd8, 8'h60, 8'h01, 1'b1);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_valid", bus.tx_valid, 1'b0);
        chk("t6_rst_read", bus.reg_read, 1'b0);
        chk("t6_rst_data", bus.tx_data, 8'h00);
        chk("t6_rst_bytecount", bus.reg_bytecount, 16'h0000);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        g0 = got_q.size();
        start_frame(6'h02, 16'd1, 8'hD0, 8'h01, 1'b1);
        wait_idle(0, 100);
        chk("t6_count", got_q.size() - g0, 4);
        for (int i = 0; i < 4; i++) chk("t6_byte", got_q[g0 + i], t6[i]);

        g0 = got_q.size(); b0 = total_busy;
        start_frame(6'h2A, 16'd300, 8'h01, 8'h07, 1'b1);
        wait_idle(0, 1000);
        chk("t7_busy_cycles", total_busy - b0, 303);
        chk("t7_len_lo", got_q[g0 + 1], 8'h2C);
        chk("t7_len_hi", got_q[g0 + 2], 8'h01);

        pat_base = 8'h5A; pat_mul = 8'h0D;
        for (int c = 0; c < 4000; c++) begin
            bus.rd_start = ($urandom_range(0, 9) == 0);
            bus.rd_cmd   = 6'($urandom);
            bus.rd_len   = 16'($urandom_range(0, 20));
            bus.tx_ready = 1'($urandom_range(0, 1));
            rst_n        = !(c >= 2000 && c < 2002);
            step();
        end
        bus.rd_start = 1'b0;
        rst_n = 1'b1;
        wait_idle(0, 300);
        step();
        chk("soak_end_idle", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/cmd_responder.md
# cmd_responder

Transmit side of the host serial command protocol. When the command handler accepts a read command, this block frames the response and streams it to the USB/serial transmitter: an echoed header, a 16-bit little-endian length, then the requested register bytes. It fetches the register bytes through a one-cycle-latency read port and buffers them in a small prefetch FIFO, so transmitter back-pressure never stalls the register side mid-byte.

## Interface
Parameters:
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk_usb  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- rd_start  in  1  one-cycle pulse requesting a response frame.
- rd_cmd  in  6  command index echoed in the header.
- rd_len  in  16  number of data bytes to send; 0 is legal.
- busy  out  1  high from the cycle after an accepted rd_start until the last byte handshakes.
- reg_read  out  1  one-cycle register fetch strobe.
- reg_bytecount  out  16  byte index being fetched, 0..rd_len-1.
- reg_data_out  in  8  register byte, valid exactly 1 cycle after reg_read.
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.

## Operation
- A byte transfers on the rising edge where tx_valid && tx_ready.
- rd_start is accepted only when busy=0. It is ignored while busy=1. On acceptance, latch rd_cmd and rd_len, and clear the fetch counter and FIFO.
- Frame order: {2'b10, cmd}, len[7:0], len[15:8], then data bytes 0..len-1.
- States:
  - IDLE: on accepted rd_start, go to HDR.
  - HDR: go to LEN_LO on handshake.
  - LEN_LO: go to LEN_HI on handshake.
  - LEN_HI: on handshake, go to DATA if len≠0, else IDLE.
  - DATA: go to IDLE on the handshake of byte len-1.
- Fetch engine (separate from the tx FSM):
  - Runs from acceptance until len bytes have been requested.
  - Issues reg_read=1 with reg_bytecount=k when (FIFO occupancy + in-flight fetches) < FIFO_DEPTH.
  - At most one fetch per cycle. k increments after each fetch.
  - Fetching overlaps HDR/LEN states.
- Capture: the cycle after reg_read, push reg_data_out into the FIFO.
- DATA: tx_data is the FIFO head; tx_valid = FIFO not empty. Pop on handshake.
- tx_data/tx_valid come from registers or FIFO storage only, never combinationally from tx_ready.
- Arithmetic: 16-bit fetch and send counters. len=65535 sends 65535 data bytes; no wrap to 0.
- The FIFO never overflows by construction. An overflow or underflow push/pop is a design error; the bench asserts it never happens.

## Timing
- Reset values: busy=0, reg_read=0, reg_bytecount=0, tx_valid=0, tx_data=0. State is IDLE, FIFO empty.
- Reset asserted mid-frame aborts the frame immediately. No further bytes are sent after release.
- Latency:
  - rd_start at cycle 0 → busy=1 and tx_valid=1 with the header at cycle 1.
  - First reg_read at cycle 1.
- Once tx_valid=1, tx_data and tx_valid hold until the handshake.
- With tx_ready held high, bytes go out back-to-back: 3+len consecutive cycles, no bubbles, provided FIFO_DEPTH≥2.
- busy falls the cycle after the final handshake. A new rd_start is accepted in that same cycle (busy=0).
- rd_start in the same cycle as the final handshake is ignored, because busy is still 1.
- A tx_ready pulse while tx_valid=0 has no effect.

## Test plan
- cmd=0x05, len=3, tx_ready=1, register byte i = 0xA0+i → tx stream 0x85,0x03,0x00,0xA0,0xA1,0xA2 on 6 consecutive cycles; reg_bytecount 0,1,2; busy low after.
- cmd=0x3F, len=0 → 0xBF,0x00,0x00; no reg_read ever asserted; busy=1 for exactly 3 cycles with tx_ready=1.
- len=10, tx_ready random 30% duty → same 13-byte sequence with data intact. Reg fetches never exceed FIFO_DEPTH outstanding. tx_data stable while stalled.
- len=16 with tx_ready=0 for 20 cycles after the header → exactly 4 reg_read pulses, then none until the first data pop.
- rd_start pulsed again mid-frame with cmd=0x01 → ignored; the original frame completes unchanged.
- rst_n low at data byte 2 of len=8, then rd_start cmd=0x02, len=1 → clean frame 0x82,0x01,0x00,D0 with no residue from the aborted frame.
